// File: rtl/mesh_pe_pkg.sv
// Shared definitions for the mesh PE: command encoding and FSM states.
package mesh_pe_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_NOP     = 3'd0;
    localparam op_t OP_SHIFT_U = 3'd1;
    localparam op_t OP_SHIFT_D = 3'd2;
    localparam op_t OP_SHIFT_L = 3'd3;
    localparam op_t OP_SHIFT_R = 3'd4;
    localparam op_t OP_MAC     = 3'd5;
    localparam op_t OP_CLEAR   = 3'd6;
    localparam op_t OP_LOAD    = 3'd7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MAC  = 1'b1
    } state_t;

    // True for commands that address a pixel slot through cmd_img.
    function automatic logic is_slot_op(input op_t op);
        return (op == OP_SHIFT_U) || (op == OP_SHIFT_D) ||
               (op == OP_SHIFT_L) || (op == OP_SHIFT_R) || (op == OP_LOAD);
    endfunction

endpackage

// File: rtl/mesh_pe_mac_if.sv
// Command handshake, neighbour links and result bus of one mesh PE.
interface mesh_pe_mac_if
    import mesh_pe_pkg::*;
#(
    parameter int PRECISION        = 8,
    parameter int NUM_IMAGES       = 4,
    parameter int OUTPUT_PRECISION = 32
);
    localparam int IDX_W = $clog2(NUM_IMAGES);

    logic                        cmd_valid;
    op_t                         cmd_op;
    logic [IDX_W-1:0]            cmd_img;
    logic [PRECISION-1:0]        load_data;
    logic                        cmd_ready;
    logic [PRECISION-1:0]        isu, isd, isl, isr;
    logic [PRECISION-1:0]        osu, osd, osl, osr;
    logic [OUTPUT_PRECISION-1:0] s_out;
    logic                        done;
    logic                        ovf;
    logic                        error;

    modport master (
        output cmd_valid, cmd_op, cmd_img, load_data, isu, isd, isl, isr,
        input  cmd_ready, osu, osd, osl, osr, s_out, done, ovf, error
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_img, load_data, isu, isd, isl, isr,
        output cmd_ready, osu, osd, osl, osr, s_out, done, ovf, error
    );
endinterface

// File: rtl/pe_mac_unit.sv
// Registered accumulator: adds one unsigned pixel-pair product per enabled
// cycle, wraps modulo 2^OUTPUT_PRECISION and keeps a sticky carry-out flag.
module pe_mac_unit #(
    parameter int PRECISION        = 8,
    parameter int OUTPUT_PRECISION = 32
) (
    input  logic                        CLK,
    input  logic                        reset,
    input  logic                        i_en,
    input  logic                        i_clear,
    input  logic [PRECISION-1:0]        i_a,
    input  logic [PRECISION-1:0]        i_b,
    output logic [OUTPUT_PRECISION-1:0] o_acc,
    output logic                        o_ovf
);
    logic [2*PRECISION-1:0]      w_prod;
    logic [OUTPUT_PRECISION:0]   w_sum;
    logic [OUTPUT_PRECISION-1:0] r_acc;
    logic                        r_ovf;

    assign w_prod = (2*PRECISION)'(i_a) * (2*PRECISION)'(i_b);
    assign w_sum  = {1'b0, r_acc} + (OUTPUT_PRECISION+1)'(w_prod);

    // Accumulate the product; the extra sum bit is the wrap indicator.
    always_ff @(posedge CLK or posedge reset) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples pre-edge values, independent of block ordering.
        if (reset) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (i_clear) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (i_en) begin
            r_acc <= w_sum[OUTPUT_PRECISION-1:0];
            if (w_sum[OUTPUT_PRECISION]) r_ovf <= 1'b1;
        end
    end

    assign o_acc = r_acc;
    assign o_ovf = r_ovf;
endmodule

// File: rtl/mesh_pe_mac.sv
// Mesh processing element: pixel slot array, neighbour shift exchange,
// command FSM and a multi-cycle pairwise MAC over all slots.
module mesh_pe_mac
    import mesh_pe_pkg::*;
#(
    parameter int PRECISION        = 8,
    parameter int NUM_IMAGES       = 4,
    parameter int OUTPUT_PRECISION = 32
) (
    input logic         CLK,
    input logic         reset,
    mesh_pe_mac_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_IMAGES);

    state_t               r_state;
    logic                 r_cmd_ready;
    logic                 r_done;
    logic                 r_error;
    logic [IDX_W-1:0]     r_pair;
    logic [PRECISION-1:0] r_slot [NUM_IMAGES];

    logic                        w_accept;
    logic                        w_idx_ok;
    logic                        w_slot_wr;
    logic                        w_last;
    logic [IDX_W-1:0]            w_idx_lo;
    logic [IDX_W-1:0]            w_idx_hi;
    logic [PRECISION-1:0]        w_rd;
    logic [PRECISION-1:0]        w_wdata;
    logic [PRECISION-1:0]        w_osu, w_osd, w_osl, w_osr;
    logic [OUTPUT_PRECISION-1:0] w_acc;
    logic                        w_ovf;

    assign w_accept  = bus.cmd_valid && r_cmd_ready;
    assign w_idx_ok  = ({1'b0, bus.cmd_img} < (IDX_W+1)'(NUM_IMAGES));
    assign w_slot_wr = w_accept && w_idx_ok && is_slot_op(bus.cmd_op);
    assign w_last    = (r_pair == IDX_W'(NUM_IMAGES/2 - 1));
    assign w_idx_lo  = IDX_W'({r_pair, 1'b0});
    assign w_idx_hi  = IDX_W'({r_pair, 1'b1});
    assign w_rd      = r_slot[bus.cmd_img];

    // Pick the write source and drive only the outgoing link that matches
    // the accepted shift direction.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned and infers a latch.
        w_wdata = bus.load_data;
        w_osu   = '0;
        w_osd   = '0;
        w_osl   = '0;
        w_osr   = '0;
        case (bus.cmd_op)
            OP_SHIFT_U: w_wdata = bus.isu;
            OP_SHIFT_D: w_wdata = bus.isd;
            OP_SHIFT_L: w_wdata = bus.isl;
            OP_SHIFT_R: w_wdata = bus.isr;
            default:    w_wdata = bus.load_data;
        endcase
        if (w_accept && w_idx_ok) begin
            case (bus.cmd_op)
                OP_SHIFT_U: w_osu = w_rd;
                OP_SHIFT_D: w_osd = w_rd;
                OP_SHIFT_L: w_osl = w_rd;
                OP_SHIFT_R: w_osr = w_rd;
                default: ;
            endcase
        end
    end

    // Slot array: written by accepted shifts and loads only.
    always_ff @(posedge CLK or posedge reset) begin
        // NOTE: the slot array is small and must read as zero after reset,
        // so every entry is reset explicitly rather than left uninitialised.
        if (reset) begin
            for (int i = 0; i < NUM_IMAGES; i++) r_slot[i] <= '0;
        end else if (w_slot_wr) begin
            r_slot[bus.cmd_img] <= w_wdata;
        end
    end

    // Command FSM with registered ready/done/error.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_pair      <= '0;
        end else begin
            r_done <= 1'b0;
            if (bus.cmd_valid && !r_cmd_ready) r_error <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (is_slot_op(bus.cmd_op)) begin
                            if (w_idx_ok) r_done  <= 1'b1;
                            else          r_error <= 1'b1;
                        end else if (bus.cmd_op == OP_CLEAR) begin
                            r_done <= 1'b1;
                        end else if (bus.cmd_op == OP_MAC) begin
                            r_state     <= ST_MAC;
                            r_cmd_ready <= 1'b0;
                            r_pair      <= '0;
                        end
                    end
                end
                ST_MAC: begin
                    if (w_last) begin
                        r_state     <= ST_IDLE;
                        r_cmd_ready <= 1'b1;
                        r_done      <= 1'b1;
                    end else begin
                        r_pair <= r_pair + IDX_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    pe_mac_unit #(
        .PRECISION       (PRECISION),
        .OUTPUT_PRECISION(OUTPUT_PRECISION)
    ) u_mac (
        .CLK    (CLK),
        .reset  (reset),
        .i_en   (r_state == ST_MAC),
        .i_clear(w_accept && (bus.cmd_op == OP_CLEAR)),
        .i_a    (r_slot[w_idx_hi]),
        .i_b    (r_slot[w_idx_lo]),
        .o_acc  (w_acc),
        .o_ovf  (w_ovf)
    );

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.done      = r_done;
    assign bus.error     = r_error;
    assign bus.s_out     = w_acc;
    assign bus.ovf       = w_ovf;
    assign bus.osu       = w_osu;
    assign bus.osd       = w_osd;
    assign bus.osl       = w_osl;
    assign bus.osr       = w_osr;
endmodule

// File: tb/tb_mesh_pe_mac.sv
// Directed bench for mesh_pe_mac: default instance (A), 16-bit accumulator
// instance (B) and six-image instance (C).
module tb_mesh_pe_mac;
    import mesh_pe_pkg::*;

    logic CLK = 1'b0;
    logic reset;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   lat;
    logic seen_done;

    always #5 CLK = ~CLK;

    mesh_pe_mac_if #(.PRECISION(8), .NUM_IMAGES(4), .OUTPUT_PRECISION(32)) bus_a ();
    mesh_pe_mac_if #(.PRECISION(8), .NUM_IMAGES(4), .OUTPUT_PRECISION(16)) bus_b ();
    mesh_pe_mac_if #(.PRECISION(8), .NUM_IMAGES(6), .OUTPUT_PRECISION(32)) bus_c ();

    mesh_pe_mac #(.PRECISION(8), .NUM_IMAGES(4), .OUTPUT_PRECISION(32))
        dut_a (.CLK(CLK), .reset(reset), .bus(bus_a));
    mesh_pe_mac #(.PRECISION(8), .NUM_IMAGES(4), .OUTPUT_PRECISION(16))
        dut_b (.CLK(CLK), .reset(reset), .bus(bus_b));
    mesh_pe_mac #(.PRECISION(8), .NUM_IMAGES(6), .OUTPUT_PRECISION(32))
        dut_c (.CLK(CLK), .reset(reset), .bus(bus_c));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_cmd(input int which, input logic v, input op_t op,
                           input logic [2:0] img, input logic [7:0] data);
        case (which)
            0: begin
                bus_a.cmd_valid = v; bus_a.cmd_op = op;
                bus_a.cmd_img = img[1:0]; bus_a.load_data = data;
            end
            1: begin
                bus_b.cmd_valid = v; bus_b.cmd_op = op;
                bus_b.cmd_img = img[1:0]; bus_b.load_data = data;
            end
            default: begin
                bus_c.cmd_valid = v; bus_c.cmd_op = op;
                bus_c.cmd_img = img; bus_c.load_data = data;
            end
        endcase
    endtask

    // Drive one command for a single edge; returns at edge+1.
    task automatic cmd(input int which, input op_t op, input logic [2:0] img,
                       input logic [7:0] data);
        set_cmd(which, 1'b1, op, img, data);
        tick();
        set_cmd(which, 1'b0, OP_NOP, 3'd0, 8'd0);
    endtask

    function automatic logic done_of(input int which);
        case (which)
            0:       return bus_a.done;
            1:       return bus_b.done;
            default: return bus_c.done;
        endcase
    endfunction

    // Count edges until done, bounded so a stuck FSM cannot hang the run.
    task automatic wait_done(input int which, output int n);
        n = 0;
        while (!done_of(which) && n < 20) begin
            tick();
            n++;
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int w = 0; w < 3; w++) set_cmd(w, 1'b0, OP_NOP, 3'd0, 8'd0);
        {bus_a.isu, bus_a.isd, bus_a.isl, bus_a.isr} = '0;
        {bus_b.isu, bus_b.isd, bus_b.isl, bus_b.isr} = '0;
        {bus_c.isu, bus_c.isd, bus_c.isl, bus_c.isr} = '0;
        #1;
        check("rst_ready", bus_a.cmd_ready, 1);
        check("rst_s_out", bus_a.s_out, 0);
        check("rst_done",  bus_a.done, 0);
        check("rst_ovf",   bus_a.ovf, 0);
        check("rst_error", bus_a.error, 0);
        tick();
        tick();
        reset = 1'b0;

        // A: load 3,5,7,11 then MAC -> 3*5 + 7*11 = 92
        cmd(0, OP_LOAD, 3'd0, 8'd3);
        check("load_done", bus_a.done, 1);
        cmd(0, OP_LOAD, 3'd1, 8'd5);
        cmd(0, OP_LOAD, 3'd2, 8'd7);
        cmd(0, OP_LOAD, 3'd3, 8'd11);
        cmd(0, OP_MAC, 3'd0, 8'd0);
        check("mac_busy", bus_a.cmd_ready, 0);
        wait_done(0, lat);
        // done appears 2 edges after the accepting edge: 3rd cycle from accept
        check("mac_lat", lat, 2);
        check("mac1_sum", bus_a.s_out, 92);
        check("mac1_ready", bus_a.cmd_ready, 1);
        tick();
        check("done_pulse", bus_a.done, 0);
        cmd(0, OP_MAC, 3'd0, 8'd0);
        wait_done(0, lat);
        check("mac2_sum", bus_a.s_out, 184);
        check("mac2_ovf", bus_a.ovf, 0);
        check("a_no_err", bus_a.error, 0);

        // A: SHIFT_L on slot1 (0x22) swaps in isl=0x99
        cmd(0, OP_LOAD, 3'd1, 8'h22);
        cmd(0, OP_LOAD, 3'd0, 8'd1);
        cmd(0, OP_CLEAR, 3'd0, 8'd0);
        check("clear_a", bus_a.s_out, 0);
        bus_a.isu = 8'h11; bus_a.isd = 8'h33; bus_a.isl = 8'h99; bus_a.isr = 8'h44;
        set_cmd(0, 1'b1, OP_SHIFT_L, 3'd1, 8'd0);
        #1;
        check("shl_osl", bus_a.osl, 8'h22);
        check("shl_osu", bus_a.osu, 0);
        check("shl_osd", bus_a.osd, 0);
        check("shl_osr", bus_a.osr, 0);
        @(posedge CLK);
        #1;
        set_cmd(0, 1'b0, OP_NOP, 3'd0, 8'd0);
        #1;
        check("shl_done", bus_a.done, 1);
        check("shl_osl_idle", bus_a.osl, 0);
        cmd(0, OP_MAC, 3'd0, 8'd0);
        wait_done(0, lat);
        // 1*0x99 + 7*11 = 230
        check("shl_sum", bus_a.s_out, 230);

        // A: command while busy is ignored and flags error
        cmd(0, OP_LOAD, 3'd0, 8'd3);
        cmd(0, OP_LOAD, 3'd1, 8'd5);
        cmd(0, OP_CLEAR, 3'd0, 8'd0);
        cmd(0, OP_MAC, 3'd0, 8'd0);
        bus_a.isu = 8'hEE;
        set_cmd(0, 1'b1, OP_SHIFT_U, 3'd0, 8'd0);
        #1;
        check("busy_osu", bus_a.osu, 0);
        @(posedge CLK);
        #1;
        set_cmd(0, 1'b0, OP_NOP, 3'd0, 8'd0);
        check("busy_err", bus_a.error, 1);
        wait_done(0, lat);
        check("busy_sum", bus_a.s_out, 92);

        // B: 16-bit accumulator, all 0xFF -> 2*65025 mod 65536 = 0xFC02
        for (int i = 0; i < 4; i++) cmd(1, OP_LOAD, 3'(i), 8'hFF);
        cmd(1, OP_MAC, 3'd0, 8'd0);
        wait_done(1, lat);
        check("b_sum", bus_b.s_out, 16'hFC02);
        check("b_ovf", bus_b.ovf, 1);
        cmd(1, OP_CLEAR, 3'd0, 8'd0);
        check("b_clr_done", bus_b.done, 1);
        check("b_clr_sum", bus_b.s_out, 0);
        check("b_clr_ovf", bus_b.ovf, 0);

        // C: six images, slot 5 legal, slot 7 illegal
        for (int i = 0; i < 6; i++) cmd(2, OP_LOAD, 3'(i), 8'(i + 1));
        check("c_img5_done", bus_c.done, 1);
        check("c_img5_err", bus_c.error, 0);
        cmd(2, OP_MAC, 3'd0, 8'd0);
        wait_done(2, lat);
        check("c_lat", lat, 3);
        // 1*2 + 3*4 + 5*6 = 44
        check("c_sum", bus_c.s_out, 44);
        cmd(2, OP_LOAD, 3'd7, 8'hFF);
        check("c_bad_done", bus_c.done, 0);
        check("c_bad_err", bus_c.error, 1);
        cmd(2, OP_MAC, 3'd0, 8'd0);
        wait_done(2, lat);
        check("c_sum2", bus_c.s_out, 88);

        // A: reset in the middle of a MAC aborts without done
        cmd(0, OP_MAC, 3'd0, 8'd0);
        #3;
        reset = 1'b1;
        #1;
        check("mid_rst_ready", bus_a.cmd_ready, 1);
        check("mid_rst_sum", bus_a.s_out, 0);
        check("mid_rst_err", bus_a.error, 0);
        check("mid_rst_done", bus_a.done, 0);
        #1;
        reset = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            seen_done = seen_done | bus_a.done;
        end
        check("mid_rst_no_done", seen_done, 0);
        cmd(0, OP_MAC, 3'd0, 8'd0);
        wait_done(0, lat);
        check("mid_rst_lat", lat, 2);
        check("mid_rst_slots", bus_a.s_out, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end
endmodule
